// File: rtl/pipe_ctrl_pkg.sv
// Shared control-bundle definitions for the decode/execute/memory/writeback
// control register chain.
package pipe_ctrl_pkg;

    localparam int ADDR_W   = 5;
    localparam int OP_W     = 4;
    localparam int BUNDLE_W = 1 + OP_W + 3 * ADDR_W;

    typedef struct packed {
        logic              valid;
        logic              alu_op;
        logic              imm_op;
        logic              mem_op;
        logic              write_op;
        logic [ADDR_W-1:0] rs_addr;
        logic [ADDR_W-1:0] rt_addr;
        logic [ADDR_W-1:0] rd_addr;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '{
        valid:    1'b0,
        alu_op:   1'b0,
        imm_op:   1'b0,
        mem_op:   1'b0,
        write_op: 1'b0,
        rs_addr:  5'd0,
        rt_addr:  5'd0,
        rd_addr:  5'd0
    };

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage of control fields; bubble forces the empty bundle on the
// next edge, reset clears it immediately.
module ctrl_stage_reg
    import pipe_ctrl_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  logic  bubble,
    input  ctrl_t d,
    output ctrl_t q
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= BUBBLE;
        end else if (bubble) begin
            q <= BUBBLE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipeline_ctrl_regs.sv
// Control-path register chain D -> E -> M with stall/flush bubble injection,
// writeback address/enable decode, and retire/stall performance counters.
module pipeline_ctrl_regs
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   w_valid,
    input  logic                   w_alu_op,
    input  logic                   w_imm_op,
    input  logic                   w_mem_op,
    input  logic                   w_write_op,
    input  logic [4:0]             w_rs_addr_5,
    input  logic [4:0]             w_rt_addr_5,
    input  logic [4:0]             w_rd_addr_5,
    input  logic                   w_stall,
    input  logic                   w_flush,
    output logic                   w_dvalid,
    output logic                   w_dalu_op,
    output logic                   w_dimm_op,
    output logic                   w_dmem_op,
    output logic                   w_dwrite_op,
    output logic [4:0]             w_drs_addr_5,
    output logic [4:0]             w_drt_addr_5,
    output logic [4:0]             w_drd_addr_5,
    output logic                   w_evalid,
    output logic                   w_ealu_op,
    output logic                   w_eimm_op,
    output logic                   w_emem_op,
    output logic                   w_ewrite_op,
    output logic [4:0]             w_ers_addr_5,
    output logic [4:0]             w_ert_addr_5,
    output logic [4:0]             w_erd_addr_5,
    output logic                   w_mvalid,
    output logic                   w_malu_op,
    output logic                   w_mimm_op,
    output logic                   w_mmem_op,
    output logic                   w_mwrite_op,
    output logic [4:0]             w_wb_regfile_addr_5,
    output logic                   w_wb_en,
    output logic                   w_fd_hold,
    output logic [CNT_W-1:0]       w_retired_cnt,
    output logic [STALL_CNT_W-1:0] w_stall_cnt
);

    ctrl_t dec;
    ctrl_t d_q;
    ctrl_t e_q;
    ctrl_t m_q;
    logic  d_bubble;

    assign dec = '{
        valid:    w_valid,
        alu_op:   w_alu_op,
        imm_op:   w_imm_op,
        mem_op:   w_mem_op,
        write_op: w_write_op,
        rs_addr:  w_rs_addr_5,
        rt_addr:  w_rt_addr_5,
        rd_addr:  w_rd_addr_5
    };

    // Flush and stall both replace the decode instruction with a bubble;
    // only the hold signal distinguishes them.
    assign d_bubble  = w_flush | w_stall;
    assign w_fd_hold = w_stall & ~w_flush;

    ctrl_stage_reg u_d_reg (
        .clock  (clock),
        .reset  (reset),
        .bubble (d_bubble),
        .d      (dec),
        .q      (d_q)
    );

    ctrl_stage_reg u_e_reg (
        .clock  (clock),
        .reset  (reset),
        .bubble (1'b0),
        .d      (d_q),
        .q      (e_q)
    );

    ctrl_stage_reg u_m_reg (
        .clock  (clock),
        .reset  (reset),
        .bubble (1'b0),
        .d      (e_q),
        .q      (m_q)
    );

    assign w_dvalid     = d_q.valid;
    assign w_dalu_op    = d_q.alu_op;
    assign w_dimm_op    = d_q.imm_op;
    assign w_dmem_op    = d_q.mem_op;
    assign w_dwrite_op  = d_q.write_op;
    assign w_drs_addr_5 = d_q.rs_addr;
    assign w_drt_addr_5 = d_q.rt_addr;
    assign w_drd_addr_5 = d_q.rd_addr;

    assign w_evalid     = e_q.valid;
    assign w_ealu_op    = e_q.alu_op;
    assign w_eimm_op    = e_q.imm_op;
    assign w_emem_op    = e_q.mem_op;
    assign w_ewrite_op  = e_q.write_op;
    assign w_ers_addr_5 = e_q.rs_addr;
    assign w_ert_addr_5 = e_q.rt_addr;
    assign w_erd_addr_5 = e_q.rd_addr;

    assign w_mvalid    = m_q.valid;
    assign w_malu_op   = m_q.alu_op;
    assign w_mimm_op   = m_q.imm_op;
    assign w_mmem_op   = m_q.mem_op;
    assign w_mwrite_op = m_q.write_op;

    // rs is carried into M for bypass symmetry but nothing at writeback reads it.
    logic [4:0] unused_m_rs;
    assign unused_m_rs = m_q.rs_addr;

    assign w_wb_regfile_addr_5 = (m_q.imm_op | m_q.mem_op) ? m_q.rt_addr : m_q.rd_addr;
    assign w_wb_en = m_q.valid
                   & (m_q.alu_op | (m_q.mem_op & ~m_q.write_op))
                   & (w_wb_regfile_addr_5 != REG_ZERO);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            w_retired_cnt <= '0;
        end else if (m_q.valid) begin
            w_retired_cnt <= w_retired_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            w_stall_cnt <= '0;
        end else if (w_fd_hold && (w_stall_cnt != '1)) begin
            w_stall_cnt <= w_stall_cnt + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl_regs.sv
// Directed and randomized checks of the control register chain against an
// in-flight instruction queue model; a narrow-counter instance covers wrap/saturation.
module tb_pipeline_ctrl_regs;

    typedef struct packed {
        logic       v;
        logic       alu;
        logic       imm;
        logic       mem;
        logic       wr;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } ins_t;

    localparam ins_t NOP = '0;

    logic clock = 1'b0;
    logic reset;
    logic w_valid, w_alu_op, w_imm_op, w_mem_op, w_write_op;
    logic [4:0] w_rs_addr_5, w_rt_addr_5, w_rd_addr_5;
    logic w_stall, w_flush;

    logic w_dvalid, w_dalu_op, w_dimm_op, w_dmem_op, w_dwrite_op;
    logic [4:0] w_drs_addr_5, w_drt_addr_5, w_drd_addr_5;
    logic w_evalid, w_ealu_op, w_eimm_op, w_emem_op, w_ewrite_op;
    logic [4:0] w_ers_addr_5, w_ert_addr_5, w_erd_addr_5;
    logic w_mvalid, w_malu_op, w_mimm_op, w_mmem_op, w_mwrite_op;
    logic [4:0] w_wb_regfile_addr_5;
    logic w_wb_en, w_fd_hold;
    logic [31:0] w_retired_cnt;
    logic [15:0] w_stall_cnt;

    logic s_dvalid, s_dalu_op, s_dimm_op, s_dmem_op, s_dwrite_op;
    logic [4:0] s_drs_addr_5, s_drt_addr_5, s_drd_addr_5;
    logic s_evalid, s_ealu_op, s_eimm_op, s_emem_op, s_ewrite_op;
    logic [4:0] s_ers_addr_5, s_ert_addr_5, s_erd_addr_5;
    logic s_mvalid, s_malu_op, s_mimm_op, s_mmem_op, s_mwrite_op;
    logic [4:0] s_wb_regfile_addr_5;
    logic s_wb_en, s_fd_hold;
    logic [3:0] s_retired_cnt;
    logic [2:0] s_stall_cnt;

    always #5 clock = ~clock;

    pipeline_ctrl_regs dut (
        .clock(clock), .reset(reset),
        .w_valid(w_valid), .w_alu_op(w_alu_op), .w_imm_op(w_imm_op),
        .w_mem_op(w_mem_op), .w_write_op(w_write_op),
        .w_rs_addr_5(w_rs_addr_5), .w_rt_addr_5(w_rt_addr_5), .w_rd_addr_5(w_rd_addr_5),
        .w_stall(w_stall), .w_flush(w_flush),
        .w_dvalid(w_dvalid), .w_dalu_op(w_dalu_op), .w_dimm_op(w_dimm_op),
        .w_dmem_op(w_dmem_op), .w_dwrite_op(w_dwrite_op),
        .w_drs_addr_5(w_drs_addr_5), .w_drt_addr_5(w_drt_addr_5), .w_drd_addr_5(w_drd_addr_5),
        .w_evalid(w_evalid), .w_ealu_op(w_ealu_op), .w_eimm_op(w_eimm_op),
        .w_emem_op(w_emem_op), .w_ewrite_op(w_ewrite_op),
        .w_ers_addr_5(w_ers_addr_5), .w_ert_addr_5(w_ert_addr_5), .w_erd_addr_5(w_erd_addr_5),
        .w_mvalid(w_mvalid), .w_malu_op(w_malu_op), .w_mimm_op(w_mimm_op),
        .w_mmem_op(w_mmem_op), .w_mwrite_op(w_mwrite_op),
        .w_wb_regfile_addr_5(w_wb_regfile_addr_5), .w_wb_en(w_wb_en),
        .w_fd_hold(w_fd_hold), .w_retired_cnt(w_retired_cnt), .w_stall_cnt(w_stall_cnt)
    );

    pipeline_ctrl_regs #(.CNT_W(4), .STALL_CNT_W(3)) dut_small (
        .clock(clock), .reset(reset),
        .w_valid(w_valid), .w_alu_op(w_alu_op), .w_imm_op(w_imm_op),
        .w_mem_op(w_mem_op), .w_write_op(w_write_op),
        .w_rs_addr_5(w_rs_addr_5), .w_rt_addr_5(w_rt_addr_5), .w_rd_addr_5(w_rd_addr_5),
        .w_stall(w_stall), .w_flush(w_flush),
        .w_dvalid(s_dvalid), .w_dalu_op(s_dalu_op), .w_dimm_op(s_dimm_op),
        .w_dmem_op(s_dmem_op), .w_dwrite_op(s_dwrite_op),
        .w_drs_addr_5(s_drs_addr_5), .w_drt_addr_5(s_drt_addr_5), .w_drd_addr_5(s_drd_addr_5),
        .w_evalid(s_evalid), .w_ealu_op(s_ealu_op), .w_eimm_op(s_eimm_op),
        .w_emem_op(s_emem_op), .w_ewrite_op(s_ewrite_op),
        .w_ers_addr_5(s_ers_addr_5), .w_ert_addr_5(s_ert_addr_5), .w_erd_addr_5(s_erd_addr_5),
        .w_mvalid(s_mvalid), .w_malu_op(s_malu_op), .w_mimm_op(s_mimm_op),
        .w_mmem_op(s_mmem_op), .w_mwrite_op(s_mwrite_op),
        .w_wb_regfile_addr_5(s_wb_regfile_addr_5), .w_wb_en(s_wb_en),
        .w_fd_hold(s_fd_hold), .w_retired_cnt(s_retired_cnt), .w_stall_cnt(s_stall_cnt)
    );

    int checks = 0;
    int errors = 0;

    // pipe[0] sits in D, pipe[1] in E, pipe[2] in M.
    ins_t pipe[$];
    longint ret_n;
    longint stall_n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input ins_t i, input logic st, input logic fl);
        w_valid = i.v; w_alu_op = i.alu; w_imm_op = i.imm; w_mem_op = i.mem;
        w_write_op = i.wr; w_rs_addr_5 = i.rs; w_rt_addr_5 = i.rt; w_rd_addr_5 = i.rd;
        w_stall = st; w_flush = fl;
    endtask

    function automatic ins_t mk(input logic alu, imm, mem, wr,
                                input int rs, input int rt, input int rd);
        ins_t i;
        i.v = 1'b1; i.alu = alu; i.imm = imm; i.mem = mem; i.wr = wr;
        i.rs = 5'(rs); i.rt = 5'(rt); i.rd = 5'(rd);
        return i;
    endfunction

    function automatic ins_t rand_ins();
        ins_t i;
        i = ins_t'($urandom_range(0, 32'hFFFFF));
        i.v = ($urandom_range(0, 4) != 0);
        return i;
    endfunction

    task automatic model_reset();
        pipe = '{NOP, NOP, NOP};
        ret_n = 0;
        stall_n = 0;
    endtask

    task automatic check_all();
        ins_t d_o, e_o, m, s_d;
        logic [4:0] wb_a;
        logic wb_e;
        d_o = '{w_dvalid, w_dalu_op, w_dimm_op, w_dmem_op, w_dwrite_op,
                w_drs_addr_5, w_drt_addr_5, w_drd_addr_5};
        e_o = '{w_evalid, w_ealu_op, w_eimm_op, w_emem_op, w_ewrite_op,
                w_ers_addr_5, w_ert_addr_5, w_erd_addr_5};
        s_d = '{s_dvalid, s_dalu_op, s_dimm_op, s_dmem_op, s_dwrite_op,
                s_drs_addr_5, s_drt_addr_5, s_drd_addr_5};
        m = pipe[2];
        chk("d_reg", 32'(d_o), 32'(pipe[0]));
        chk("e_reg", 32'(e_o), 32'(pipe[1]));
        chk("small_d_reg", 32'(s_d), 32'(pipe[0]));
        chk("m_ctrl", 32'({w_mvalid, w_malu_op, w_mimm_op, w_mmem_op, w_mwrite_op}),
            32'({m.v, m.alu, m.imm, m.mem, m.wr}));
        // Loads and immediates target rt; register-register ops target rd.
        wb_a = (m.imm || m.mem) ? m.rt : m.rd;
        wb_e = m.v && (m.alu || (m.mem && !m.wr)) && (wb_a != 5'd0);
        chk("wb_addr", 32'(w_wb_regfile_addr_5), 32'(wb_a));
        chk("wb_en", 32'(w_wb_en), 32'(wb_e));
        chk("retired_cnt", w_retired_cnt, 32'(ret_n % 64'h1_0000_0000));
        chk("stall_cnt", 32'(w_stall_cnt), 32'((stall_n > 65535) ? 65535 : stall_n));
        chk("small_retired_cnt", 32'(s_retired_cnt), 32'(ret_n % 16));
        chk("small_stall_cnt", 32'(s_stall_cnt), 32'((stall_n > 7) ? 7 : stall_n));
    endtask

    // Advance one clock with the inputs currently driven.
    task automatic tick(input bit full);
        logic hold;
        ins_t nw;
        #1;
        if (w_flush) hold = 1'b0;
        else hold = w_stall;
        if (full) chk("fd_hold", 32'(w_fd_hold), 32'(hold));
        if (w_flush || w_stall) nw = NOP;
        else nw = '{w_valid, w_alu_op, w_imm_op, w_mem_op, w_write_op,
                    w_rs_addr_5, w_rt_addr_5, w_rd_addr_5};
        if (pipe[2].v) ret_n++;
        if (hold) stall_n++;
        @(posedge clock);
        pipe.push_front(nw);
        void'(pipe.pop_back());
        #1;
        if (full) check_all();
    endtask

    task automatic reset_now();
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("reset_wb_en", 32'(w_wb_en), 32'd0);
        #2;
        reset = 1'b0;
    endtask

    longint base;

    initial begin
        reset = 1'b1;
        drive(NOP, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_all();
        reset = 1'b0;

        // Randomized traffic with stalls and flushes.
        for (int n = 0; n < 300; n++) begin
            drive(rand_ins(), ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
            tick(1);
        end

        // Reset mid-stream: everything clears without a clock edge.
        drive(mk(1, 0, 0, 0, 1, 2, 3), 1'b0, 1'b0);
        reset_now();

        // add $3,$1,$2 reaches writeback after three edges.
        drive(mk(1, 0, 0, 0, 1, 2, 3), 1'b0, 1'b0);
        tick(1);
        drive(NOP, 1'b0, 1'b0);
        tick(1);
        tick(1);
        chk("add_wb_addr", 32'(w_wb_regfile_addr_5), 32'd3);
        chk("add_wb_en", 32'(w_wb_en), 32'd1);
        tick(1);
        chk("add_retired", w_retired_cnt, 32'd1);

        // Load-use: lw $5 then a dependent add held for one cycle.
        base = stall_n;
        drive(mk(0, 1, 1, 0, 1, 5, 0), 1'b0, 1'b0);
        tick(1);
        drive(mk(1, 0, 0, 0, 5, 1, 6), 1'b1, 1'b0);
        tick(1);
        chk("lu_d_bubble", 32'(w_dvalid), 32'd0);
        chk("lu_stall_cnt", 32'(w_stall_cnt), 32'(base + 1));
        drive(mk(1, 0, 0, 0, 5, 1, 6), 1'b0, 1'b0);
        tick(1);
        chk("lu_d_loaded", 32'({w_dvalid, w_drs_addr_5, w_drd_addr_5}), 32'({1'b1, 5'd5, 5'd6}));

        // Flush beats stall.
        base = stall_n;
        drive(mk(1, 0, 0, 0, 7, 8, 9), 1'b1, 1'b1);
        #1;
        chk("fl_fd_hold", 32'(w_fd_hold), 32'd0);
        tick(1);
        chk("fl_d_bubble", 32'(w_dvalid), 32'd0);
        chk("fl_stall_cnt", 32'(w_stall_cnt), 32'(base));

        // Store and write to $0 never enable writeback, but both retire.
        drive(mk(0, 0, 1, 1, 2, 4, 0), 1'b0, 1'b0);
        tick(1);
        drive(mk(0, 1, 0, 0, 1, 0, 0), 1'b0, 1'b0);
        tick(1);
        drive(NOP, 1'b0, 1'b0);
        tick(1);
        base = ret_n;
        chk("sw_wb_en", 32'(w_wb_en), 32'd0);
        tick(1);
        chk("addi0_wb_en", 32'(w_wb_en), 32'd0);
        tick(1);
        chk("sw_addi_retired", w_retired_cnt, 32'(base + 2));

        // 17 retirements wrap the 4-bit counter to 1.
        reset_now();
        for (int n = 0; n < 17; n++) begin
            drive(mk(1, 0, 0, 0, n % 32, (n + 1) % 32, (n + 2) % 32), 1'b0, 1'b0);
            tick(1);
        end
        drive(NOP, 1'b0, 1'b0);
        repeat (3) tick(1);
        chk("small_wrap", 32'(s_retired_cnt), 32'd1);

        // Stall counter saturation at 16 bits.
        reset_now();
        drive(NOP, 1'b1, 1'b0);
        repeat (65534) tick(0);
        #1;
        chk("stall_fffe", 32'(w_stall_cnt), 32'hFFFE);
        for (int n = 0; n < 3; n++) tick(1);
        chk("stall_sat", 32'(w_stall_cnt), 32'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl_regs.md
# pipeline_ctrl_regs

Control-path pipeline register chain that carries per-instruction control fields from decode through execute, memory and writeback, and produces the stage-tagged fields (`w_d*`, `w_e*`, `w_m*`, `w_wb_regfile_addr_5`) that the hazard detection controller consumes. It consumes that controller's `w_stall`, plus a branch `w_flush`, to hold fetch/decode and inject bubbles. It also keeps retire and stall performance counters.

## Interface
Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.
- `STALL_CNT_W`, default 16: width of the saturating stall-cycle counter.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `w_valid`  in  1  the decode-stage instruction is real (not a fetch bubble).
- `w_alu_op`, `w_imm_op`, `w_mem_op`, `w_write_op`  in  1 each  decode-stage control bits.
- `w_rs_addr_5`, `w_rt_addr_5`, `w_rd_addr_5`  in  5 each  decode-stage register addresses.
- `w_stall`  in  1  load-use stall request from the hazard detection controller.
- `w_flush`  in  1  taken-branch flush; kills the decode-stage instruction.
- `w_dvalid`, `w_dalu_op`, `w_dimm_op`, `w_dmem_op`, `w_dwrite_op`  out  1 each  D register (execute input).
- `w_drs_addr_5`, `w_drt_addr_5`, `w_drd_addr_5`  out  5 each  D register addresses.
- `w_evalid`, `w_ealu_op`, `w_eimm_op`, `w_emem_op`, `w_ewrite_op`  out  1 each  E register (memory input).
- `w_ers_addr_5`, `w_ert_addr_5`, `w_erd_addr_5`  out  5 each  E register addresses.
- `w_mvalid`, `w_malu_op`, `w_mimm_op`, `w_mmem_op`, `w_mwrite_op`  out  1 each  M register (writeback input).
- `w_wb_regfile_addr_5`  out  5  writeback destination of the M instruction.
- `w_wb_en`  out  1  register-file write enable for the M instruction.
- `w_fd_hold`  out  1  hold the PC and the fetch/decode register this cycle.
- `w_retired_cnt`  out  CNT_W  count of valid instructions that have left M.
- `w_stall_cnt`  out  STALL_CNT_W  count of stall cycles, saturating.

## Operation
- Bubble: valid=0, all op bits 0, all addresses 0.
- D update, in priority order: flush -> bubble; stall -> bubble; otherwise load the decode inputs (valid = `w_valid`).
- E <= D and M <= E every cycle, unconditionally; stall and flush never freeze E or M.
- `w_fd_hold` = `w_stall & ~w_flush`, combinational. With flush, fetch advances to the branch target.
- Writeback address, from M:
  - `w_mimm_op | w_mmem_op` -> rt.
  - otherwise -> rd.
- `w_wb_en` = `w_mvalid & (w_malu_op | (w_mmem_op & ~w_mwrite_op)) & (w_wb_regfile_addr_5 != 0)`. Stores and bubbles never write.
- Address fields in every stage keep rs, rt and rd separately so downstream bypass compares remain valid.
- `w_retired_cnt` increments by 1 on each edge where `w_mvalid`=1, and wraps modulo 2^CNT_W.
- `w_stall_cnt` increments on each edge where `w_fd_hold`=1, and saturates at all-ones.
- Reset: every D/E/M register is a bubble, `w_wb_en`=0, both counters 0, and `w_fd_hold` follows its inputs.

## Timing
- Decode -> D: 1 cycle. D -> E: 1 cycle. E -> M: 1 cycle. Decode to writeback outputs: 3 cycles.
- Stall cycle N: D becomes a bubble at edge N. The held decode instruction re-presents in cycle N+1 and loads at edge N+1 if `w_stall` is low.
- Flush and stall in the same cycle: flush wins, D becomes a bubble, `w_fd_hold`=0, and the stall counter does not count.
- Back-to-back stalls: one bubble per stalled cycle; the stall counter increments each cycle.
- Reset asserted mid-operation: all in-flight instructions are discarded asynchronously; there is no partial retire. The first edge after deassertion loads D normally.
- Counter wrap and saturation take effect on the same edge as the triggering event.

## Structure
- The shared package `pipe_ctrl_pkg` holds:
  - the control-field bundle width constants;
  - the bubble constant (valid/op bits 0, addresses 5'd0);
  - the `REG_ZERO` constant (5'd0).
- One sub-module, `ctrl_stage_reg`, is instantiated three times (D, E, M). It is an asynchronously reset register for one control bundle with a `bubble` input that forces the bubble value.
- The writeback-address mux, the write-enable logic and both counters live in the top level.

## Test plan
- Reset: `reset`=1 mid-stream -> all valid/op outputs 0, both counters 0, `w_wb_en`=0 at once with no clock edge; after release, add $3,$1,$2 (alu, rd=3) reaches M after 3 edges with `w_wb_regfile_addr_5`=3, `w_wb_en`=1, and `w_retired_cnt`=1 one edge later.
- Load-use: lw $5 (mem, ~write, imm, rt=5), then `w_stall`=1 for one cycle -> `w_fd_hold`=1, D=bubble for one edge, the held add loads on the next edge, and `w_stall_cnt`=1.
- Flush with stall: `w_flush`=1 and `w_stall`=1 together -> D=bubble, `w_fd_hold`=0, `w_stall_cnt` unchanged.
- Store and zero: sw (mem, write) -> `w_wb_en`=0; addi $0 (imm, rt=0) -> `w_wb_en`=0. Both still increment `w_retired_cnt`.
- Saturation and wrap:
  - Preload `w_stall_cnt` to 0xFFFE, then 3 stall cycles -> `w_stall_cnt` reaches 0xFFFF and holds.
  - With CNT_W=4, retire 17 instructions -> `w_retired_cnt`=1.
